// File: rtl/ddr_act_cas_sched_pkg.sv
// Shared types for the DDR4 ACT/CAS scheduling stage: command opcodes,
// decoded memory address, scheduler FSM states, rw encodings and the
// CAS address builder (closed-page, A10 set for auto-precharge).
package ddr_act_cas_sched_pkg;

  // Command opcode presented on cmd_op; DES when no command is driven.
  typedef enum logic [1:0] {
    DES = 2'd0,
    ACT = 2'd1,
    RD  = 2'd2,
    WR  = 2'd3
  } cmd_op_t;

  // Decoded transaction address as delivered by the request queue.
  typedef struct packed {
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [17:0] row;
    logic [9:0]  col;
  } mem_addr_type;

  // Scheduler FSM states, also exported for debug.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ACT      = 3'd1,
    S_TRCD     = 3'd2,
    S_CAS_WAIT = 3'd3,
    S_CAS      = 3'd4
  } sched_state_t;

  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  localparam int ADDR_W = 18;

  // Column address with A10=1 so every CAS closes the page behind it.
  function automatic logic [ADDR_W-1:0] cas_addr(input logic [9:0] col);
    return {7'd0, 1'b1, col};
  endfunction

endpackage

// File: rtl/ddr_act_cas_sched_if.sv
// Request channel between the transaction queue (master) and the
// ACT/CAS scheduler (slave).
//
// Handshake: a transfer happens on every rising clock edge where
// req_valid and req_ready are both 1. The master holds req_rw/req_addr
// stable while req_valid is 1 and may not retract it before the transfer;
// req_ready may change freely when req_valid is 0.
interface ddr_act_cas_sched_if;
  import ddr_act_cas_sched_pkg::*;

  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_rw;
  mem_addr_type req_addr;

  modport master (output req_valid, output req_rw, output req_addr, input req_ready);
  modport slave  (input req_valid, input req_rw, input req_addr, output req_ready);

endinterface

// File: rtl/ddr_act_cas_sched_tmr_cnt.sv
// ddr_tmr_cnt: loadable down-counter for one DRAM timing constraint.
// A load value of 0 is treated as 1. The counter holds the number of
// cycles still to wait and saturates at 0; expired is 1 at 0.
module ddr_tmr_cnt #(
  parameter int TW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          expired
);

  logic [TW-1:0] cnt;

  // Load on request, otherwise count down and stick at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (load_val == '0) ? '0 : load_val - TW'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - TW'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/ddr_act_cas_sched.sv
// ddr_act_cas_sched: request-to-command stage of the DDR4 controller.
// Accepts one decoded transaction, issues ACT, waits tRCD, then issues a
// RD/WR with auto-precharge once tCCD has elapsed and the data stage is
// ready. One transaction in flight at a time.
//
// Optional build macro: DDR_SCHED_PERF_EN adds perf_act/perf_rd/perf_wr
// command counters.
//
// Timer alignment: each timer is loaded on the clock edge that commits
// its command (accept edge for tRCD/tRRD, edge into CAS for tCCD). A timer
// reading 0 in a cycle therefore means the dependent command may be
// issued in the following cycle, which gives accept-to-CAS = 1 + t_rcd,
// ACT-to-ACT >= t_rrd and CAS-to-CAS >= t_ccd exactly.
module ddr_act_cas_sched
  import ddr_act_cas_sched_pkg::*;
#(
  parameter int TW     = 8,
  parameter int PERF_W = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 config_done,
  input  logic [TW-1:0]        t_rcd,
  input  logic [TW-1:0]        t_ccd,
  input  logic [TW-1:0]        t_rrd,
  ddr_act_cas_sched_if.slave   req,
  input  logic                 dn_ready,
  output logic                 cmd_valid,
  output cmd_op_t              cmd_op,
  output logic [1:0]           cmd_bg,
  output logic [1:0]           cmd_ba,
  output logic [ADDR_W-1:0]    cmd_a,
  output logic                 act_rdy,
  output logic [1:0]           act_rw,
  output logic                 cas_rdy,
  output logic [1:0]           cas_rw,
  output logic                 act_idle,
  output logic                 cas_idle,
  output sched_state_t         state_dbg
`ifdef DDR_SCHED_PERF_EN
  ,
  output logic [PERF_W-1:0]    perf_act,
  output logic [PERF_W-1:0]    perf_rd,
  output logic [PERF_W-1:0]    perf_wr
`endif
);

  if (TW < 1 || PERF_W < 1) begin : g_param_check
    $error("ddr_act_cas_sched: TW and PERF_W must be at least 1");
  end

  sched_state_t state, next_state;
  logic [1:0]   rw_q;
  mem_addr_type addr_q;

  logic rw_legal;
  logic accept;
  logic take;
  logic trcd_exp, ccd_exp, rrd_exp;
  logic cas_go;
  logic ccd_load;

  assign rw_legal = (req.req_rw == RW_READ) || (req.req_rw == RW_WRITE);

  // Reset is folded in so the port reads 0 while reset is held.
  assign req.req_ready = (state == S_IDLE) && config_done && rrd_exp && !reset;
  assign accept        = req.req_valid && req.req_ready;
  // Illegal rw codes are consumed but never become a transaction.
  assign take          = accept && rw_legal;

  assign cas_go   = trcd_exp && ccd_exp && dn_ready;
  assign ccd_load = (next_state == S_CAS);

  ddr_tmr_cnt #(.TW(TW)) u_trcd (
    .clock    (clock),
    .reset    (reset),
    .load     (take),
    .load_val (t_rcd),
    .expired  (trcd_exp)
  );

  ddr_tmr_cnt #(.TW(TW)) u_tccd (
    .clock    (clock),
    .reset    (reset),
    .load     (ccd_load),
    .load_val (t_ccd),
    .expired  (ccd_exp)
  );

  ddr_tmr_cnt #(.TW(TW)) u_trrd (
    .clock    (clock),
    .reset    (reset),
    .load     (take),
    .load_val (t_rrd),
    .expired  (rrd_exp)
  );

  // State register plus capture of the accepted transaction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      rw_q   <= 2'b00;
      addr_q <= '0;
    end else begin
      state <= next_state;
      if (take) begin
        rw_q   <= req.req_rw;
        addr_q <= req.req_addr;
      end
    end
  end

  // Next-state selection; CAS is entered straight from ACT/TRCD when all
  // gating conditions already hold so no bubble is added.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (take) next_state = S_ACT;
      end
      S_ACT, S_TRCD: begin
        if (cas_go)        next_state = S_CAS;
        else if (trcd_exp) next_state = S_CAS_WAIT;
        else               next_state = S_TRCD;
      end
      S_CAS_WAIT: begin
        if (ccd_exp && dn_ready) next_state = S_CAS;
      end
      S_CAS: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Command bus and status pulses decoded from the current state.
  always_comb begin
    cmd_valid = 1'b0;
    cmd_op    = DES;
    cmd_bg    = 2'b00;
    cmd_ba    = 2'b00;
    cmd_a     = '0;
    act_rdy   = 1'b0;
    act_rw    = 2'b00;
    cas_rdy   = 1'b0;
    cas_rw    = 2'b00;
    case (state)
      S_ACT: begin
        cmd_valid = 1'b1;
        cmd_op    = ACT;
        cmd_bg    = addr_q.bg;
        cmd_ba    = addr_q.ba;
        cmd_a     = addr_q.row;
        act_rdy   = 1'b1;
        act_rw    = rw_q;
      end
      S_CAS: begin
        cmd_valid = 1'b1;
        cmd_op    = (rw_q == RW_WRITE) ? WR : RD;
        cmd_bg    = addr_q.bg;
        cmd_ba    = addr_q.ba;
        cmd_a     = cas_addr(addr_q.col);
        cas_rdy   = 1'b1;
        cas_rw    = rw_q;
      end
      default: begin
      end
    endcase
  end

  assign act_idle  = (state == S_IDLE);
  assign cas_idle  = ccd_exp;
  assign state_dbg = state;

`ifdef DDR_SCHED_PERF_EN
  // Free-running command counters; wrap naturally at 2**PERF_W.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_act <= '0;
      perf_rd  <= '0;
      perf_wr  <= '0;
    end else begin
      if (state == S_ACT)                      perf_act <= perf_act + PERF_W'(1);
      if (state == S_CAS && rw_q != RW_WRITE)  perf_rd  <= perf_rd + PERF_W'(1);
      if (state == S_CAS && rw_q == RW_WRITE)  perf_wr  <= perf_wr + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ddr_act_cas_sched.sv
// Directed testbench for ddr_act_cas_sched. Build with DDR_SCHED_PERF_EN
// defined to also exercise the performance counters.
module tb_ddr_act_cas_sched;
  import ddr_act_cas_sched_pkg::*;

  localparam int TW     = 8;
  localparam int PERF_W = 32;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          config_done;
  logic [TW-1:0] t_rcd, t_ccd, t_rrd;
  logic          dn_ready;
  logic          cmd_valid;
  cmd_op_t       cmd_op;
  logic [1:0]    cmd_bg, cmd_ba;
  logic [17:0]   cmd_a;
  logic          act_rdy, cas_rdy;
  logic [1:0]    act_rw, cas_rw;
  logic          act_idle, cas_idle;
  sched_state_t  state_dbg;
`ifdef DDR_SCHED_PERF_EN
  logic [PERF_W-1:0] perf_act, perf_rd, perf_wr;
`endif

  ddr_act_cas_sched_if req_if ();

  ddr_act_cas_sched #(.TW(TW), .PERF_W(PERF_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .config_done (config_done),
    .t_rcd       (t_rcd),
    .t_ccd       (t_ccd),
    .t_rrd       (t_rrd),
    .req         (req_if),
    .dn_ready    (dn_ready),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_bg      (cmd_bg),
    .cmd_ba      (cmd_ba),
    .cmd_a       (cmd_a),
    .act_rdy     (act_rdy),
    .act_rw      (act_rw),
    .cas_rdy     (cas_rdy),
    .cas_rw      (cas_rw),
    .act_idle    (act_idle),
    .cas_idle    (cas_idle),
    .state_dbg   (state_dbg)
`ifdef DDR_SCHED_PERF_EN
    ,
    .perf_act    (perf_act),
    .perf_rd     (perf_rd),
    .perf_wr     (perf_wr)
`endif
  );

  // ---------------- scoreboard / monitor ----------------
  int n_cmp = 0;
  int n_err = 0;

  int      act_cycs[$];
  int      cas_cycs[$];
  logic [17:0] last_act_a, last_cas_a;
  logic [1:0]  last_act_bg, last_act_ba;
  cmd_op_t     last_cas_op;
  logic [1:0]  last_act_rw, last_cas_rw;
  int          n_act_rdy = 0, n_cas_rdy = 0;
  int          act_rdy_cyc = -1, cas_rdy_cyc = -1;

  always @(negedge clock) begin
    if (!reset) begin
      if (cmd_valid && cmd_op == ACT) begin
        act_cycs.push_back(cyc);
        last_act_a  = cmd_a;
        last_act_bg = cmd_bg;
        last_act_ba = cmd_ba;
      end
      if (cmd_valid && (cmd_op == RD || cmd_op == WR)) begin
        cas_cycs.push_back(cyc);
        last_cas_a  = cmd_a;
        last_cas_op = cmd_op;
      end
      if (act_rdy) begin
        n_act_rdy++;
        act_rdy_cyc = cyc;
        last_act_rw = act_rw;
      end
      if (cas_rdy) begin
        n_cas_rdy++;
        cas_rdy_cyc = cyc;
        last_cas_rw = cas_rw;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic mem_addr_type mk_addr(input logic [1:0] bg, input logic [1:0] ba,
                                           input logic [17:0] row, input logic [9:0] col);
    mem_addr_type a;
    a.bg = bg; a.ba = ba; a.row = row; a.col = col;
    return a;
  endfunction

  // Present one request and return the cycle in which it was accepted.
  task automatic send(input logic [1:0] rw, input mem_addr_type a, output int acc_cyc);
    req_if.req_valid = 1'b1;
    req_if.req_rw    = rw;
    req_if.req_addr  = a;
    acc_cyc = -1;
    for (int i = 0; i < 300 && acc_cyc < 0; i++) begin
      if (req_if.req_ready) acc_cyc = cyc;
      tick(1);
    end
    req_if.req_valid = 1'b0;
    check("send_accept", 32'(acc_cyc >= 0), 32'd1);
  endtask

  task automatic wait_cas(input int n0);
    int k;
    k = 0;
    while (cas_cycs.size() <= n0 && k < 300) begin
      tick(1);
      k++;
    end
    check("cas_wait", 32'(cas_cycs.size() > n0), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int acc, acc2, c, r, n0, a0;
  logic seen;

  initial begin
    reset       = 1'b1;
    config_done = 1'b0;
    dn_ready    = 1'b1;
    t_rcd = 8'd3; t_ccd = 8'd2; t_rrd = 8'd2;
    req_if.req_valid = 1'b0;
    req_if.req_rw    = 2'b00;
    req_if.req_addr  = '0;
    tick(3);

    // Reset values
    check("rst_act_idle",  32'(act_idle),  32'd1);
    check("rst_cas_idle",  32'(cas_idle),  32'd1);
    check("rst_cmd_op",    32'(cmd_op),    32'(DES));
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_req_ready", 32'(req_if.req_ready), 32'd0);
    check("rst_act_rdy",   32'(act_rdy),   32'd0);
    reset = 1'b0;
    tick(2);

    // 1: no accept while config_done is low, ACT the cycle after it rises
    req_if.req_valid = 1'b1;
    req_if.req_rw    = RW_READ;
    req_if.req_addr  = mk_addr(2'd0, 2'd0, 18'h10, 10'h8);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      seen = seen | req_if.req_ready;
      tick(1);
    end
    check("t1_ready_low", 32'(seen), 32'd0);
    check("t1_no_act", 32'(act_cycs.size()), 32'd0);
    config_done = 1'b1;
    c = cyc;
    tick(1);
    req_if.req_valid = 1'b0;
    wait_cas(0);
    check("t1_act_cycle", 32'(act_cycs.size() > 0 ? act_cycs[0] : -1), 32'(c + 1));
    tick(5);

    // 2: single read, t_rcd=11
    t_rcd = 8'd11;
    n0 = cas_cycs.size();
    a0 = n_act_rdy;
    send(RW_READ, mk_addr(2'd1, 2'd2, 18'h1234, 10'h040), acc);
    wait_cas(n0);
    check("t2_act_cycle",  32'(act_cycs[$]), 32'(acc + 1));
    check("t2_act_a",      32'(last_act_a), 32'h1234);
    check("t2_act_bgba",   32'({last_act_bg, last_act_ba}), 32'h6);
    check("t2_cas_cycle",  32'(cas_cycs[$]), 32'(acc + 12));
    check("t2_cas_a",      32'(last_cas_a), 32'h440);
    check("t2_cas_op",     32'(last_cas_op), 32'(RD));
    check("t2_act_rdy_cyc", 32'(act_rdy_cyc), 32'(acc + 1));
    check("t2_cas_rdy_cyc", 32'(cas_rdy_cyc), 32'(acc + 12));
    check("t2_act_rdy_n",  32'(n_act_rdy - a0), 32'd1);
    check("t2_cas_rdy_n",  32'(n_cas_rdy - n0), 32'd1);
    check("t2_act_rw",     32'(last_act_rw), 32'(RW_READ));
    check("t2_cas_rw",     32'(last_cas_rw), 32'(RW_READ));
    tick(10);

    // 3: back-to-back writes, tCCD dominates CAS spacing
    t_rcd = 8'd2; t_ccd = 8'd6; t_rrd = 8'd4;
    tick(10);
    n0 = cas_cycs.size();
    a0 = act_cycs.size();
    send(RW_WRITE, mk_addr(2'd2, 2'd1, 18'h00AA, 10'h011), acc);
    send(RW_WRITE, mk_addr(2'd3, 2'd0, 18'h0BBB, 10'h022), acc2);
    wait_cas(n0 + 1);
    check("t3_act_space", 32'(act_cycs[a0 + 1] - act_cycs[a0]), 32'd4);
    check("t3_cas_space", 32'(cas_cycs[n0 + 1] - cas_cycs[n0]), 32'd6);
    check("t3_cas_op",    32'(last_cas_op), 32'(WR));
    check("t3_cas_rw",    32'(last_cas_rw), 32'(RW_WRITE));
    check("t3_cas_a",     32'(last_cas_a), 32'h422);
    tick(10);

    // 4: data stage not ready, hold in CAS_WAIT
    t_rcd = 8'd3; t_ccd = 8'd2; t_rrd = 8'd2;
    tick(5);
    dn_ready = 1'b0;
    n0 = cas_cycs.size();
    send(RW_READ, mk_addr(2'd0, 2'd3, 18'h2222, 10'h3FF), acc);
    tick(23);
    check("t4_state_hold", 32'(state_dbg), 32'(S_CAS_WAIT));
    check("t4_no_cas",     32'(cas_cycs.size()), 32'(n0));
    dn_ready = 1'b1;
    r = cyc;
    wait_cas(n0);
    check("t4_cas_cycle",  32'(cas_cycs[$]), 32'(r + 1));
    check("t4_cas_a",      32'(last_cas_a), 32'h7FF);
    tick(5);

    // 5: reset the cycle after ACT
    t_rcd = 8'd5;
    n0 = cas_cycs.size();
    send(RW_READ, mk_addr(2'd1, 2'd1, 18'h3333, 10'h001), acc);
    tick(1);
    reset = 1'b1;
    #1;
    check("t5_act_idle",  32'(act_idle),  32'd1);
    check("t5_cas_idle",  32'(cas_idle),  32'd1);
    check("t5_cmd_valid", 32'(cmd_valid), 32'd0);
    check("t5_cmd_op",    32'(cmd_op),    32'(DES));
    check("t5_state",     32'(state_dbg), 32'(S_IDLE));
    tick(2);
    reset = 1'b0;
    tick(20);
    check("t5_no_cas", 32'(cas_cycs.size()), 32'(n0));

    // 6: illegal rw dropped, then 3 reads + 2 writes
    t_rcd = 8'd2; t_ccd = 8'd2; t_rrd = 8'd2;
    a0 = act_cycs.size();
    n0 = cas_cycs.size();
    send(2'b11, mk_addr(2'd0, 2'd0, 18'h0444, 10'h004), acc);
    tick(10);
    check("t6_illegal_no_act", 32'(act_cycs.size()), 32'(a0));
    check("t6_illegal_idle",   32'(act_idle), 32'd1);
    send(RW_READ,  mk_addr(2'd0, 2'd1, 18'h0010, 10'h010), acc);
    send(RW_WRITE, mk_addr(2'd1, 2'd0, 18'h0020, 10'h020), acc);
    send(RW_READ,  mk_addr(2'd2, 2'd1, 18'h0030, 10'h030), acc);
    send(RW_WRITE, mk_addr(2'd3, 2'd2, 18'h0040, 10'h040), acc);
    send(RW_READ,  mk_addr(2'd0, 2'd3, 18'h0050, 10'h050), acc);
    wait_cas(n0 + 4);
    tick(3);
    check("t6_act_n", 32'(act_cycs.size() - a0), 32'd5);
    check("t6_cas_n", 32'(cas_cycs.size() - n0), 32'd5);
`ifdef DDR_SCHED_PERF_EN
    check("t6_perf_act", perf_act, 32'd5);
    check("t6_perf_rd",  perf_rd,  32'd3);
    check("t6_perf_wr",  perf_wr,  32'd2);
    send(2'b11, mk_addr(2'd0, 2'd0, 18'h0001, 10'h001), acc);
    tick(10);
    check("t6_perf_act_ill", perf_act, 32'd5);
    check("t6_perf_rd_ill",  perf_rd,  32'd3);
    check("t6_perf_wr_ill",  perf_wr,  32'd2);
`endif

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
